muldiv_hilo: RTL and testbench

Iterative multiply/divide unit that owns the architectural HI/LO register pair. It sits beside the execute stage and directly feeds it.
- Execute issues MULT/MULTU/DIV/DIVU/MTHI/MTLO to this block.
- Execute consumes HI/LO for MFHI/MFLO and stalls on Busy.

---
 rtl/muldiv_hilo.sv | 173 +++++++++++++++++
 tb/tb_muldiv_hilo.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/muldiv_hilo.sv
// Iterative multiply/divide unit owning the HI/LO pair (shift-add multiply, restoring divide).
// Optional macro FAST_MULT_EN: single-cycle combinational multiply; divide stays iterative.
module muldiv_hilo #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic [5:0]       Funct,
    input  logic [WIDTH-1:0] Rdata1,
    input  logic [WIDTH-1:0] Rdata2,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    // state | meaning
    // IDLE  | waiting for an issue
    // RUN   | one multiply/divide iteration per edge
    // FIX   | sign correction, HI/LO written at the end of this cycle
    // DONE  | result visible, Done pulses; new issues accepted
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_q, neg_d;
    logic                 neg_rem_q, neg_rem_d;
    logic                 dz_q, dz_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;

    logic                 accept, is_mul, is_divop, is_signed, sa, sb;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [WIDTH:0]       msum, dshift;
    logic [WIDTH-1:0]     ddiff, quot, rem;
    logic                 dge;
    logic [2*WIDTH-1:0]   mul_next, div_next, prod_src, prod;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign Busy   = (state_q == S_RUN) || (state_q == S_FIX);
    assign Done   = (state_q == S_DONE);
    assign HI     = hi_q;
    assign LO     = lo_q;
    assign accept = Start && !Busy;

    assign is_mul    = (Funct == F_MULT) || (Funct == F_MULTU);
    assign is_divop  = (Funct == F_DIV)  || (Funct == F_DIVU);
    assign is_signed = (Funct == F_MULT) || (Funct == F_DIV);
    assign sa        = is_signed && Rdata1[WIDTH-1];
    assign sb        = is_signed && Rdata2[WIDTH-1];
    assign mag_a     = sa ? -Rdata1 : Rdata1;
    assign mag_b     = sb ? -Rdata2 : Rdata2;

    // Multiply: acc = {partial product high, remaining multiplier bits}
    assign msum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next = {msum, acc_q[WIDTH-1:1]};

    // Divide: acc = {partial remainder, dividend bits shifting into quotient}
    assign dshift   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign dge      = dshift >= {1'b0, opnd_q};
    assign ddiff    = dshift[WIDTH-1:0] - opnd_q;
    assign div_next = {(dge ? ddiff : dshift[WIDTH-1:0]), acc_q[WIDTH-2:0], dge};

`ifdef FAST_MULT_EN
    logic [2*WIDTH-1:0] fast_prod;
    assign fast_prod = {{WIDTH{1'b0}}, opnd_q} * {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]};
    assign prod_src  = is_div_q ? acc_q : fast_prod;
`else
    assign prod_src  = acc_q;
`endif

    assign prod = neg_q ? -prod_src : prod_src;
    assign quot = acc_q[WIDTH-1:0];
    assign rem  = acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept) begin
                    if (is_mul || is_divop) begin
                        cnt_d     = '0;
                        is_div_d  = is_divop;
                        neg_d     = sa ^ sb;
                        neg_rem_d = sa;
                        dz_d      = (Rdata2 == '0);
                        opnd_d    = is_divop ? mag_b : mag_a;
                        acc_d     = {{WIDTH{1'b0}}, (is_divop ? mag_a : mag_b)};
`ifdef FAST_MULT_EN
                        state_d   = is_mul ? S_FIX : S_RUN;
`else
                        state_d   = S_RUN;
`endif
                    end else if (Funct == F_MTHI) begin
                        hi_d = Rdata1;
                    end else if (Funct == F_MTLO) begin
                        lo_d = Rdata1;
                    end
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + 1'b1;
                acc_d = is_div_q ? div_next : mul_next;
                if (cnt_q == LAST_ITER) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                cnt_d   = '0;
                state_d = S_DONE;
                if (is_div_q) begin
                    // Divide by zero leaves the remainder equal to the dividend as given
                    lo_d = dz_q ? '1 : (neg_q ? -quot : quot);
                    hi_d = neg_rem_q ? -rem : rem;
                end else begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_muldiv_hilo.sv
// Directed self-checking bench for muldiv_hilo; honours FAST_MULT_EN when defined.
module tb_muldiv_hilo;

    logic        CLK = 1'b0;
    logic        RST;
    logic        Start;
    logic [5:0]  Funct;
    logic [31:0] Rdata1, Rdata2;
    logic        Busy, Done;
    logic [31:0] HI, LO;

    int n_cmp = 0;
    int n_err = 0;

`ifdef FAST_MULT_EN
    localparam int MUL_BUSY = 1;
`else
    localparam int MUL_BUSY = 33;
`endif
    localparam int DIV_BUSY = 33;

    muldiv_hilo #(.WIDTH(32)) dut (
        .CLK(CLK), .RST(RST), .Start(Start), .Funct(Funct),
        .Rdata1(Rdata1), .Rdata2(Rdata2),
        .Busy(Busy), .Done(Done), .HI(HI), .LO(LO)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Wait for Done with a cycle budget, counting Busy cycles and watching HI/LO stay put.
    task automatic wait_done(input logic [31:0] h0, input logic [31:0] l0,
                             output int busy_n, output bit held);
        busy_n = 0;
        held   = 1'b1;
        for (int i = 0; i < 100 && !Done; i++) begin
            if (Busy) busy_n++;
            if (HI !== h0 || LO !== l0) held = 1'b0;
            tick();
        end
    endtask

    task automatic do_op(input string tag, input logic [5:0] f,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input int exp_busy);
        logic [31:0] h0, l0;
        int          busy_n;
        bit          held;
        h0 = HI;
        l0 = LO;
        Start = 1'b1; Funct = f; Rdata1 = a; Rdata2 = b;
        tick();
        Start = 1'b0;
        wait_done(h0, l0, busy_n, held);
        chk({tag, "_done"}, 32'(Done), 32'd1);
        chk({tag, "_busy_cycles"}, 32'(busy_n), 32'(exp_busy));
        chk({tag, "_hilo_held"}, 32'(held), 32'd1);
        chk({tag, "_hi"}, HI, exp_hi);
        chk({tag, "_lo"}, LO, exp_lo);
        tick();
        chk({tag, "_done_pulse"}, 32'(Done), 32'd0);
    endtask

    initial begin
        int busy_n;
        bit held;
        bit done_seen;

        RST = 1'b1; Start = 1'b0; Funct = 6'h00; Rdata1 = '0; Rdata2 = '0;
        tick();
        tick();
        RST = 1'b0;
        chk("rst_hi", HI, 32'h0);
        chk("rst_lo", LO, 32'h0);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);

        do_op("multu_max", 6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MUL_BUSY);
        do_op("mult_neg",  6'h18, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, MUL_BUSY);
        do_op("div_neg",   6'h1A, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, DIV_BUSY);
        do_op("divu_zero", 6'h1B, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, DIV_BUSY);
        do_op("div_zero",  6'h1A, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF, DIV_BUSY);
        do_op("div_ovf",   6'h1A, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DIV_BUSY);

        // MTHI while idle
        Start = 1'b1; Funct = 6'h11; Rdata1 = 32'h12345678;
        tick();
        Start = 1'b0;
        chk("mthi_hi", HI, 32'h12345678);
        chk("mthi_lo", LO, 32'h80000000);
        chk("mthi_busy", 32'(Busy), 32'd0);
        chk("mthi_done", 32'(Done), 32'd0);

        // MFHI is a no-op
        Start = 1'b1; Funct = 6'h10; Rdata1 = 32'hDEADBEEF;
        tick();
        Start = 1'b0;
        chk("mfhi_busy", 32'(Busy), 32'd0);
        chk("mfhi_hi", HI, 32'h12345678);

        // MTLO issued mid-divide is ignored
        Start = 1'b1; Funct = 6'h1B; Rdata1 = 32'd100; Rdata2 = 32'd7;
        tick();
        Start = 1'b0;
        repeat (4) tick();
        Start = 1'b1; Funct = 6'h13; Rdata1 = 32'h0000AAAA;
        tick();
        Start = 1'b0;
        chk("mtlo_busy_lo", LO, 32'h80000000);
        chk("mtlo_busy_flag", 32'(Busy), 32'd1);
        wait_done(32'h12345678, 32'h80000000, busy_n, held);
        chk("divu_mid_done", 32'(Done), 32'd1);
        chk("divu_mid_held", 32'(held), 32'd1);
        chk("divu_mid_lo", LO, 32'd14);
        chk("divu_mid_hi", HI, 32'd2);
        tick();

        // Reset in the middle of a multiply
        Start = 1'b1; Funct = 6'h18; Rdata1 = 32'd5; Rdata2 = 32'd6;
        tick();
        Start = 1'b0;
        repeat (9) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("rstmid_hi", HI, 32'h0);
        chk("rstmid_lo", LO, 32'h0);
        chk("rstmid_busy", 32'(Busy), 32'd0);
        done_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (Done) done_seen = 1'b1;
            tick();
        end
        chk("rstmid_no_done", 32'(done_seen), 32'd0);
        chk("rstmid_hi_after", HI, 32'h0);

        do_op("multu_small", 6'h19, 32'd3, 32'd5, 32'h0, 32'd15, MUL_BUSY);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
